// File: rtl/vga_sync_decoder.sv
// Rebuilds hcount/vcount/blanking from incoming hsync/vsync, one clock behind the source,
// and tracks whether the incoming sync timing is locked to the expected raster.
module vga_sync_decoder #(
    parameter int H_TOTAL    = 1344,
    parameter int H_ACTIVE   = 1024,
    parameter int H_S_START  = 1048,
    parameter int V_TOTAL    = 806,
    parameter int V_ACTIVE   = 768,
    parameter int V_S_START  = 771,
    parameter int LOCK_LINES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hblnk,
    output logic        vblnk,
    output logic        locked,
    output logic        new_frame,
    output logic        sync_err
);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_S_START);
    localparam logic [10:0] H_PRE  = 11'(H_S_START - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS   = 11'(V_S_START);
    localparam logic [10:0] V_PRE  = 11'(V_S_START - 1);
    localparam int          LW     = (LOCK_LINES > 1) ? $clog2(LOCK_LINES) : 1;
    localparam logic [LW-1:0] LC_LAST = LW'(LOCK_LINES - 1);
    localparam logic [LW-1:0] LC_ONE  = LW'(1);
    localparam logic [LW-1:0] LC_ZERO = LW'(0);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        H_ACQ  = 2'd1,
        V_ACQ  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic          hs_q_r, vs_q_r;
    logic [10:0]   hcount_r, vcount_r, hcount_nxt_s, vcount_nxt_s;
    logic [LW-1:0] line_cnt_r, line_cnt_nxt_s;
    logic          hblnk_r, vblnk_r, locked_r, new_frame_r, sync_err_r;
    logic          hs_rise_s, vs_rise_s, h_wrap_s, h_ok_s, h_bad_s, v_bad_s, err_s;

    // Sync edge detection and the timing-check terms derived from the local counters
    always_comb begin
        hs_rise_s = hsync & ~hs_q_r;
        vs_rise_s = vsync & ~vs_q_r;
        h_wrap_s  = (hcount_r >= H_LAST);
        h_ok_s    = hs_rise_s & (hcount_r == H_PRE);
        h_bad_s   = (hs_rise_s & (hcount_r != H_PRE)) | (~hs_rise_s & (hcount_r == H_PRE));
        v_bad_s   = vs_rise_s ^ ((hcount_r == H_LAST) & (vcount_r == V_PRE));
    end

    // Counter next-state: sync reloads win over increment and wrap
    always_comb begin
        hcount_nxt_s = hcount_r;
        vcount_nxt_s = vcount_r;
        if (hs_rise_s) begin
            hcount_nxt_s = H_SS;
        end else if (h_wrap_s) begin
            hcount_nxt_s = 11'd0;
        end else begin
            hcount_nxt_s = hcount_r + 11'd1;
        end
        if (vs_rise_s && ((state_r == V_ACQ) || (state_r == LOCKED))) begin
            vcount_nxt_s = V_SS;
        end else if (h_wrap_s) begin
            if (vcount_r >= V_LAST) begin
                vcount_nxt_s = 11'd0;
            end else begin
                vcount_nxt_s = vcount_r + 11'd1;
            end
        end else begin
            vcount_nxt_s = vcount_r;
        end
    end

    // Lock FSM next-state; errors are only reported once fully locked
    always_comb begin
        state_nxt_s    = state_r;
        line_cnt_nxt_s = line_cnt_r;
        err_s          = 1'b0;
        case (state_r)
            SEARCH: begin
                if (hs_rise_s) begin
                    line_cnt_nxt_s = LC_ZERO;
                    state_nxt_s    = H_ACQ;
                end else begin
                    state_nxt_s = SEARCH;
                end
            end
            H_ACQ: begin
                if (h_bad_s) begin
                    state_nxt_s = SEARCH;
                end else if (h_ok_s) begin
                    if (line_cnt_r == LC_LAST) begin
                        state_nxt_s = V_ACQ;
                    end else begin
                        line_cnt_nxt_s = line_cnt_r + LC_ONE;
                    end
                end else begin
                    state_nxt_s = H_ACQ;
                end
            end
            V_ACQ: begin
                if (h_bad_s) begin
                    state_nxt_s = SEARCH;
                end else if (vs_rise_s) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = V_ACQ;
                end
            end
            LOCKED: begin
                if (h_bad_s || v_bad_s) begin
                    err_s       = 1'b1;
                    state_nxt_s = SEARCH;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = SEARCH;
            end
        endcase
    end

    // State, counters and registered outputs (decodes taken from next values so they align)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SEARCH;
            hs_q_r      <= 1'b0;
            vs_q_r      <= 1'b0;
            hcount_r    <= 11'd0;
            vcount_r    <= 11'd0;
            line_cnt_r  <= LC_ZERO;
            hblnk_r     <= 1'b0;
            vblnk_r     <= 1'b0;
            locked_r    <= 1'b0;
            new_frame_r <= 1'b0;
            sync_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hs_q_r      <= hsync;
            vs_q_r      <= vsync;
            hcount_r    <= hcount_nxt_s;
            vcount_r    <= vcount_nxt_s;
            line_cnt_r  <= line_cnt_nxt_s;
            hblnk_r     <= (hcount_nxt_s >= H_ACT);
            vblnk_r     <= (vcount_nxt_s >= V_ACT);
            locked_r    <= (state_nxt_s == LOCKED);
            new_frame_r <= (state_r == LOCKED) && (hcount_r == H_LAST) && (vcount_r == V_LAST);
            sync_err_r  <= err_s;
        end
    end

    assign hcount    = hcount_r;
    assign vcount    = vcount_r;
    assign hblnk     = hblnk_r;
    assign vblnk     = vblnk_r;
    assign locked    = locked_r;
    assign new_frame = new_frame_r;
    assign sync_err  = sync_err_r;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken raster (40x20) driven by a
// bench-side timing source; expected values are the source counts delayed one clock.
module tb_vga_sync_decoder;

    localparam int HT = 40, HA = 24, HS = 28, HW = 4;
    localparam int VT = 20, VA = 14, VS = 16, VW = 2, LL = 4;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [10:0] hcount, vcount;
    logic        hblnk, vblnk, locked, new_frame, sync_err;

    int total = 0, bad = 0;
    int src_h = 0, src_v = 0, exp_h = 0, exp_v = 0;
    int drop_line = -1, hold_line = -1;
    bit early_v = 1'b0, track = 1'b0;
    int nf_cnt = 0, err_cnt = 0, err_h = -1, err_v = -1, err_hc = -1, err_vc = -1;
    bit err_locked = 1'b1;
    int n = 0;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_S_START(HS),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_S_START(VS), .LOCK_LINES(LL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .hcount(hcount), .vcount(vcount), .hblnk(hblnk), .vblnk(vblnk),
        .locked(locked), .new_frame(new_frame), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (src h=%0d v=%0d)", tag, got, exp, exp_h, exp_v);
        end
    endtask

    // One pixel clock: present the next source state, then sample mid-cycle
    task automatic step();
        @(posedge clk);
        #1;
        exp_h = src_h;
        exp_v = src_v;
        if (src_h == HT - 1) begin
            src_h = 0;
            src_v = (src_v == VT - 1) ? 0 : src_v + 1;
        end else begin
            src_h = src_h + 1;
        end
        hsync = ((src_h >= HS) && (src_h < HS + HW) && (src_v != drop_line)) ||
                ((hold_line >= 0) && (((src_v == hold_line) && (src_h >= HS)) ||
                                      (src_v == hold_line + 1) ||
                                      ((src_v == hold_line + 2) && (src_h < HS))));
        vsync = early_v ? ((src_v >= VS - 1) && (src_v < VS - 1 + VW))
                        : ((src_v >= VS) && (src_v < VS + VW));
        @(negedge clk);
        if (sync_err) begin
            err_cnt++;
            err_h = exp_h; err_v = exp_v; err_hc = int'(hcount); err_vc = int'(vcount);
            err_locked = locked;
        end
        if (new_frame) nf_cnt++;
        if (track)
            check_eq("track", {5'd0, hcount, vcount, hblnk, vblnk, new_frame, sync_err, locked},
                     {5'd0, 11'(exp_h), 11'(exp_v), exp_h >= HA, exp_v >= VA,
                      (exp_h == 0) && (exp_v == 0), 1'b0, 1'b1});
    endtask

    task automatic run_to_frame_start();
        for (int i = 0; i < FRAME && !(src_h == 0 && src_v == 0); i++) step();
    endtask

    task automatic wait_lock(input string tag, input int budget);
        n = 0;
        while (!locked && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_locked"}, locked, 1);
        check_eq({tag, "_pos"}, {exp_h[15:0], exp_v[15:0]}, {16'd0, 16'(VS)});
        check_eq({tag, "_vcount"}, vcount, VS);
    endtask

    task automatic clear_err();
        err_cnt = 0; err_h = -1; err_v = -1; err_hc = -1; err_vc = -1; err_locked = 1'b1;
    endtask

    initial begin
        #12;
        check_eq("rst_outs", {hcount, vcount, hblnk, vblnk, locked, new_frame, sync_err}, 0);
        #20 rst_n = 1'b1;

        // Initial acquisition: lock at the first vsync, inside frame 0
        wait_lock("init", FRAME);
        check_eq("init_in_frame", n < FRAME, 1);

        // Steady lock over three frames
        track = 1'b1; nf_cnt = 0; clear_err();
        repeat (3 * FRAME) step();
        track = 1'b0;
        check_eq("steady_new_frame", nf_cnt, 3);
        check_eq("steady_no_err", err_cnt, 0);

        // Dropped hsync pulse in line 3
        run_to_frame_start();
        drop_line = 3; clear_err();
        repeat (10 * HT) step();
        drop_line = -1;
        check_eq("drop_err_cnt", err_cnt, 1);
        check_eq("drop_err_pos", {err_h[15:0], err_v[15:0]}, {16'(HS), 16'd3});
        check_eq("drop_err_hcount", err_hc, HS);
        check_eq("drop_unlock", err_locked, 0);
        check_eq("drop_still_unlocked", locked, 0);
        wait_lock("drop_relock", FRAME);

        // Vsync one line early
        run_to_frame_start();
        early_v = 1'b1; clear_err();
        repeat (17 * HT) step();
        check_eq("early_err_cnt", err_cnt, 1);
        check_eq("early_err_pos", {err_h[15:0], err_v[15:0]}, {16'd0, 16'(VS - 1)});
        check_eq("early_vreload", err_vc, VS);
        check_eq("early_unlock", err_locked, 0);
        run_to_frame_start();
        early_v = 1'b0;
        wait_lock("early_relock", FRAME);

        // Hsync held high across two line starts
        run_to_frame_start();
        hold_line = 5; clear_err();
        repeat (10 * HT) step();
        check_eq("hold_err_cnt", err_cnt, 1);
        check_eq("hold_err_pos", {err_h[15:0], err_v[15:0]}, {16'(HS), 16'd6});
        check_eq("hold_err_hcount", err_hc, HS);
        check_eq("hold_unlock", err_locked, 0);
        wait_lock("hold_relock", FRAME);
        hold_line = -1;

        // Asynchronous reset in the middle of line 2
        run_to_frame_start();
        repeat (2 * HT + 20) step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async", {hcount, vcount, hblnk, vblnk, locked, new_frame, sync_err}, 0);
        repeat (3) step();
        check_eq("rst_hold", {hcount, vcount, hblnk, vblnk, locked, new_frame, sync_err}, 0);
        #2 rst_n = 1'b1;
        wait_lock("rst_relock", FRAME + 4 * HT);

        // Tracking after recovery
        track = 1'b1; nf_cnt = 0; clear_err();
        repeat (FRAME) step();
        track = 1'b0;
        check_eq("post_rst_new_frame", nf_cnt, 1);
        check_eq("post_rst_no_err", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive end of the VGA timing interface: takes hsync/vsync as driven by the team's 1024x768 timing generator and regenerates hcount/vcount/hblnk/vblnk locally, one clock behind the source.
- A lock FSM verifies the sync period and position and flags timing errors.
- Used on capture/overlay paths and as a self-check monitor on the timing generator output.

Parameters:
- H_TOTAL, 1344, clocks per line.
- H_ACTIVE, 1024, visible pixels per line; hblnk when hcount >= H_ACTIVE.
- H_S_START, 1048, hcount of the first hsync-high pixel.
- V_TOTAL, 806, lines per frame.
- V_ACTIVE, 768, visible lines; vblnk when vcount >= V_ACTIVE.
- V_S_START, 771, vcount of the first vsync-high line; vsync rises at hcount 0.
- LOCK_LINES, 4, consecutive correctly spaced hsync edges needed before vertical acquisition.

Ports:
- clk  in  1  pixel clock (65 MHz)
- rst_n  in  1  asynchronous, active-low reset
- hsync  in  1  active-high horizontal sync, synchronous to clk
- vsync  in  1  active-high vertical sync, synchronous to clk
- hcount  out  11  regenerated horizontal count
- vcount  out  11  regenerated vertical count
- hblnk  out  1  hcount >= H_ACTIVE (decoded from registered hcount)
- vblnk  out  1  vcount >= V_ACTIVE (decoded from registered vcount)
- locked  out  1  high in LOCKED state
- new_frame  out  1  1-cycle pulse, first cycle with hcount = 0 and vcount = 0 while locked
- sync_err  out  1  1-cycle pulse on a timing violation while locked

Behaviour:
- Reset (rst_n low, asynchronous): hcount = 0, vcount = 0, hs_q = 0, vs_q = 0, line_cnt = 0, state = SEARCH. All outputs are 0.
- Edge detect: hs_q and vs_q register the inputs. hs_rise = hsync & ~hs_q; vs_rise = vsync & ~vs_q.
- hcount free-runs: 0..H_TOTAL-1, then wraps to 0.
- vcount increments when hcount = H_TOTAL-1 and wraps after V_TOTAL-1.
- hs_rise in any state: hcount <= H_S_START next cycle. This reload has priority over the increment.
- vs_rise in V_ACQ or LOCKED: vcount <= V_S_START. This has priority over the increment and wrap, including a coincident line wrap.
- Latency: when the source drives hcount = H_S_START, the decoder's registered hcount equals H_S_START-1. The decoder shows H_S_START one clock later. All outputs lag the source by exactly 1 clk.
- h_ok = hs_rise & (hcount == H_S_START-1).
- h_bad = (hs_rise & hcount != H_S_START-1) | (~hs_rise & hcount == H_S_START-1).
- v_bad = vs_rise XOR (hcount == H_TOTAL-1 & vcount == V_S_START-1).
- FSM SEARCH: counters free-run. On hs_rise: line_cnt <= 0, go to H_ACQ.
- FSM H_ACQ: on h_ok, line_cnt++. When line_cnt reaches LOCK_LINES-1 on an h_ok, go to V_ACQ. On h_bad, go to SEARCH. No sync_err is raised in this state.
- FSM V_ACQ: on h_bad, go to SEARCH. On the first vs_rise (any position), reload vcount and go to LOCKED.
- FSM LOCKED: on h_bad or v_bad, pulse sync_err for the cycle after the violation and go to SEARCH.
  - locked falls in that same cycle.
  - The hsync reload still applies, so the next hs_rise restarts acquisition.
- new_frame: registered. It asserts the cycle after hcount = H_TOTAL-1 and vcount = V_TOTAL-1 while in LOCKED, aligned with hcount = 0, vcount = 0.
- Simultaneous hs_rise and vs_rise: both reloads apply, and each is evaluated independently for error.
- Sync held high continuously: no rise occurs, so the missing edge produces h_bad.
- All arithmetic is 11-bit unsigned. The wrap compare uses >= TOTAL-1 so that out-of-range values recover.

Test Plan:
- Connect to a reference timing generator, release reset, and run 2 frames. Required:
  - locked is high before the first frame completes.
  - Afterwards, hcount/vcount/hblnk/vblnk equal the generator's values delayed by 1 clk, every cycle.
  - new_frame pulses once per 1344*806 = 1,083,264 clks.
- Steady lock: assert hcount = 1048 exactly 1 clk after each source hsync rise. Assert vcount = 771 at the first vsync-high cycle + 1. No sync_err over 3 frames.
- Drop one hsync pulse in line 300 of a locked frame. Required:
  - sync_err pulses once, 1 clk after decoder hcount = 1047.
  - locked falls.
  - Relock after LOCK_LINES hsync pulses plus the next vsync.
- Shift a vsync pulse 1 line early in a locked stream: sync_err pulse at the early vs_rise, state goes to SEARCH.
- Assert rst_n low mid-line (hcount near 500) for 3 clks. Required:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, lock recovers within 1 frame plus 4 lines.
- Hold hsync high for 2 lines: h_bad at the expected position, sync_err pulse, no second reload until hsync falls and rises again.
